// File: rtl/expu_inverse_correction_if.sv
// Request/response stream bundle for the exponent-unit inverse mantissa correction.
interface expu_inverse_correction_if #(
  parameter int N = 7
);
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] mantissa_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] mantissa_o;
  logic         exact_o;

  modport slave (
    input  valid_i, mantissa_i, ready_i,
    output ready_o, valid_o, mantissa_o, exact_o
  );

  modport master (
    output valid_i, mantissa_i, ready_i,
    input  ready_o, valid_o, mantissa_o, exact_o
  );
endinterface

// File: rtl/expu_inverse_correction.sv
// Recovers the uncorrected mantissa m whose forward correction f(m) is the largest
// value not exceeding the target T, via MSB-first bisection (one bit per cycle).
module expu_inverse_correction #(
  parameter int INPUT_FRACTION       = 7,
  parameter int COEFFICIENT_FRACTION = 7,
  parameter int CONSTANT_FRACTION    = 7,
  parameter int MUL_SURPLUS_BITS     = 1,
  parameter int NOT_SURPLUS_BITS     = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  expu_inverse_correction_if.slave       bus
);

  localparam int N   = INPUT_FRACTION;
  localparam int CF  = COEFFICIENT_FRACTION;
  localparam int KF  = CONSTANT_FRACTION;
  localparam int S   = MUL_SURPLUS_BITS;
  localparam int NS  = NOT_SURPLUS_BITS;
  localparam int SF  = (N > KF) ? N : KF;
  localparam int AW  = N - 1 + S;
  localparam int CW  = CF + 1;
  localparam int GW  = KF + 2;
  localparam int P1W = N + CF + S - 2;
  localparam int SW  = SF + 2;
  localparam int P2W = P1W + SW;
  localparam int SH  = SF + CF + S - NS;
  localparam int RW  = N + NS;
  localparam int KW  = (N > 1) ? $clog2(N) : 1;

  localparam real LN2 = 0.6931471805599453;
  localparam real AR  = 0.27055988837249;
  localparam real BR  = 0.4294429717321613;

  // int'() of a real rounds to nearest, matching the coefficient definition
  localparam int ALPHA   = int'(AR * real'(2 ** CF));
  localparam int BETA    = int'(BR * real'(2 ** CF));
  localparam int GAMMA_1 = int'((LN2 / AR) * real'(2 ** KF));
  localparam int GAMMA_2 = int'((2.0 * LN2 / BR - 1.0) * real'(2 ** KF));

  localparam logic [CW-1:0] ALPHA_C = CW'(ALPHA);
  localparam logic [CW-1:0] BETA_C  = CW'(BETA);
  localparam logic [GW-1:0] G1_C    = GW'(GAMMA_1);
  localparam logic [GW-1:0] G2_C    = GW'(GAMMA_2);

  function automatic logic [N-1:0] f_corr(input logic [N-1:0] m);
    logic [AW-1:0]  a;
    logic [CW-1:0]  coef;
    logic [GW-1:0]  gamma;
    logic [P1W-1:0] p1;
    logic [SW-1:0]  sum;
    logic [P2W-1:0] p2;
    logic [RW-1:0]  r;
    logic [RW-1:0]  rs;
    a     = AW'(m[N-2:0]) << S;
    if (m[N-1]) a = ~a;
    coef  = m[N-1] ? BETA_C : ALPHA_C;
    gamma = m[N-1] ? G2_C : G1_C;
    p1    = P1W'((AW + CW)'(a) * (AW + CW)'(coef));
    sum   = (SW'(m) << (SF - N)) + (SW'(gamma) << (SF - KF));
    p2    = P2W'(p1) * P2W'(sum);
    r     = RW'(p2 >> SH);
    rs    = m[N-1] ? ~r : r;
    return N'(rs >> NS);
  endfunction

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_t;
  logic [N-1:0]   r_res;
  logic [N-1:0]   r_fr;
  logic [KW-1:0]  r_k;
  logic           r_exact;

  logic [N-1:0]   w_cand;
  logic [N-1:0]   w_fc;
  logic           w_take;
  logic [N-1:0]   w_fnext;

  assign w_cand  = r_res | (N'(1) << r_k);
  assign w_fc    = f_corr(w_cand);
  assign w_take  = (w_fc <= r_t);
  // f of the running result is tracked so exact_o needs no second f evaluation
  assign w_fnext = w_take ? w_fc : r_fr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.valid_i) w_next = SEARCH;
      SEARCH:  if (r_k == '0) w_next = DONE;
      DONE:    if (bus.ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear_i) w_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_t     <= '0;
      r_res   <= '0;
      r_fr    <= '0;
      r_k     <= '0;
      r_exact <= 1'b0;
    end else if (clear_i) begin
      r_t     <= '0;
      r_res   <= '0;
      r_fr    <= '0;
      r_k     <= '0;
      r_exact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.valid_i) begin
            r_t     <= bus.mantissa_i;
            r_res   <= '0;
            r_fr    <= '0;
            r_k     <= KW'(N - 1);
            r_exact <= 1'b0;
          end
        end
        SEARCH: begin
          if (w_take) begin
            r_res <= w_cand;
            r_fr  <= w_fc;
          end
          r_k <= r_k - 1'b1;
          if (r_k == '0) r_exact <= (w_fnext == r_t);
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o    = (r_state == IDLE);
  assign bus.valid_o    = (r_state == DONE);
  assign bus.mantissa_o = r_res;
  assign bus.exact_o    = r_exact;

endmodule

// File: tb/tb_expu_inverse_correction.sv
// Directed and exhaustive-target bench for expu_inverse_correction at default parameters.
module tb_expu_inverse_correction;

  logic clk;
  logic rst_n;
  logic clear;
  int   errors;
  int   checks;

  expu_inverse_correction_if #(.N(7)) bus ();

  expu_inverse_correction #(
    .INPUT_FRACTION(7),
    .COEFFICIENT_FRACTION(7),
    .CONSTANT_FRACTION(7),
    .MUL_SURPLUS_BITS(1),
    .NOT_SURPLUS_BITS(0)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clear_i(clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic model written with plain integer division/modulo at N=7, CF=KF=7, S=1
  function automatic int model_f(input int m);
    int a, coef, g, p1, sum, r;
    if (m < 64) begin
      a = (m % 64) * 2;  coef = 35; g = 328;
    end else begin
      a = 127 - (m % 64) * 2;  coef = 55; g = 285;
    end
    p1  = (a * coef) % 8192;
    sum = (m + g) % 512;
    r   = ((p1 * sum) / 32768) % 128;
    return (m >= 64) ? (127 - r) : r;
  endfunction

  function automatic int model_search(input int t);
    int r, c;
    r = 0;
    for (int k = 6; k >= 0; k--) begin
      c = r | (1 << k);
      if (model_f(c) <= t) r = c;
    end
    return r;
  endfunction

  // Issues one request and waits (bounded) for valid_o; leaves ready_i low, at a negedge.
  task automatic do_txn(input logic [6:0] t, output logic [6:0] m, output logic ex, output int lat);
    @(negedge clk);
    bus.valid_i = 1'b1; bus.mantissa_i = t; bus.ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 0;
    while (bus.valid_o !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    m  = bus.mantissa_o;
    ex = bus.exact_o;
  endtask

  task automatic release_out();
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_o); end
    checks++; if (bus.mantissa_o !== 7'd0) begin errors++; $display("FAIL reset_mant got=%0d exp=0", bus.mantissa_o); end
    checks++; if (bus.exact_o !== 1'b0) begin errors++; $display("FAIL reset_exact got=%b exp=0", bus.exact_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [6:0] tv [4] = '{7'd53, 7'd24, 7'd127, 7'd0};
    logic [6:0] ev [4] = '{7'd64, 7'd32, 7'd127, 7'd1};
    logic [6:0] m;
    logic ex;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_txn(tv[i], m, ex, lat);
      checks++; if (lat !== 7) begin errors++; $display("FAIL vec_latency T=%0d got=%0d exp=7", tv[i], lat); end
      checks++; if (m !== ev[i]) begin errors++; $display("FAIL vec_mant T=%0d got=%0d exp=%0d", tv[i], m, ev[i]); end
      checks++; if (ex !== 1'b1) begin errors++; $display("FAIL vec_exact T=%0d got=%b exp=1", tv[i], ex); end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [6:0] m;
    logic ex;
    int lat;
    do_txn(7'd53, m, ex, lat);
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd24;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.valid_o); end
      checks++; if (bus.mantissa_o !== 7'd64) begin errors++; $display("FAIL bp_mant cyc=%0d got=%0d exp=64", c, bus.mantissa_o); end
      checks++; if (bus.exact_o !== 1'b1) begin errors++; $display("FAIL bp_exact cyc=%0d got=%b exp=1", c, bus.exact_o); end
      checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, bus.ready_o); end
    end
    bus.valid_i = 1'b0;
    release_out();
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.ready_o); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", bus.valid_o); end
  endtask

  task automatic test_clear();
    logic [6:0] m;
    logic ex;
    int lat;
    bit seen;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd53;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL clr_ready got=%b exp=1", bus.ready_o); end
    checks++; if (bus.mantissa_o !== 7'd0) begin errors++; $display("FAIL clr_mant got=%0d exp=0", bus.mantissa_o); end
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.valid_o !== 1'b0) seen = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clr_no_valid got=%b exp=0", seen); end
    // handshake coinciding with clear is discarded
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd24; clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0; clear = 1'b0;
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL clr_handshake_ready got=%b exp=1", bus.ready_o); end
    do_txn(7'd53, m, ex, lat);
    checks++; if (m !== 7'd64 || lat !== 7) begin errors++; $display("FAIL clr_after mant=%0d lat=%0d exp=64/7", m, lat); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int first_c, second_c;
    logic [6:0] fm, sm;
    first_c = -1; second_c = -1; fm = '0; sm = '0;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd24; bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mantissa_i = 7'd127;
    for (int c = 1; c <= 17; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        if (first_c < 0) begin first_c = c; fm = bus.mantissa_o; end
        else if (second_c < 0 && c > first_c + 1) begin second_c = c; sm = bus.mantissa_o; end
      end
    end
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    checks++; if (first_c !== 7) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=7", first_c); end
    checks++; if (fm !== 7'd32) begin errors++; $display("FAIL b2b_first_mant got=%0d exp=32", fm); end
    checks++; if (second_c !== 16) begin errors++; $display("FAIL b2b_second_cycle got=%0d exp=16", second_c); end
    checks++; if (sm !== 7'd127) begin errors++; $display("FAIL b2b_second_mant got=%0d exp=127", sm); end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_all_targets();
    logic [6:0] m, t;
    logic ex;
    int lat, off, er, ee;
    off = int'($urandom_range(0, 127));
    for (int i = 0; i < 128; i++) begin
      t  = 7'((off + i * 37) % 128);
      er = model_search(int'(t));
      ee = (model_f(er) == int'(t)) ? 1 : 0;
      do_txn(t, m, ex, lat);
      checks++; if (lat !== 7 || int'(m) !== er) begin errors++; $display("FAIL all_mant T=%0d got=%0d lat=%0d exp=%0d", t, m, lat, er); end
      checks++; if (int'(ex) !== ee) begin errors++; $display("FAIL all_exact T=%0d got=%b exp=%0d", t, ex, ee); end
      release_out();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] m;
    logic ex;
    int lat;
    @(negedge clk);
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd127;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    checks++; if (bus.mantissa_o !== 7'd96) begin errors++; $display("FAIL mid_partial got=%0d exp=96", bus.mantissa_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_hs ready=%b valid=%b exp=1/0", bus.ready_o, bus.valid_o); end
    checks++; if (bus.mantissa_o !== 7'd0 || bus.exact_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out mant=%0d exact=%b exp=0/0", bus.mantissa_o, bus.exact_o); end
    bus.valid_i = 1'b1; bus.mantissa_i = 7'd53;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    lat = 0;
    while (bus.valid_o !== 1'b1 && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    m = bus.mantissa_o; ex = bus.exact_o;
    checks++; if (lat !== 7 || m !== 7'd64 || ex !== 1'b1) begin errors++; $display("FAIL mid_first_accept lat=%0d mant=%0d exact=%b exp=7/64/1", lat, m, ex); end
    release_out();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; clear = 1'b0;
    bus.valid_i = 1'b0; bus.ready_i = 1'b0; bus.mantissa_i = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_all_targets();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expu_inverse_correction.md
EXPU_INVERSE_CORRECTION -- requirements
Module: expu_inverse_correction

Interface
REQ-001 SHALL have parameter INPUT_FRACTION (N), default 7: mantissa width, Q0.N.
REQ-002 SHALL have parameter COEFFICIENT_FRACTION (CF), default 7: ALPHA/BETA fraction bits.
REQ-003 SHALL have parameter CONSTANT_FRACTION (KF), default 7: GAMMA fraction bits.
REQ-004 SHALL have parameter MUL_SURPLUS_BITS (S), default 1: extra multiplier-operand LSBs.
REQ-005 SHALL have parameter NOT_SURPLUS_BITS (NS), default 0: extra bits kept before inversion.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk_i input 1, rising-edge clock.
REQ-007 SHALL have rst_ni input 1, asynchronous active-low reset.
REQ-008 SHALL have clear_i input 1, synchronous clear.
REQ-009 SHALL have valid_i input 1, input request.
REQ-010 SHALL have ready_o output 1, input acceptance.
REQ-011 SHALL have mantissa_i input N, corrected mantissa target T.
REQ-012 SHALL have valid_o output 1, result valid.
REQ-013 SHALL have ready_i input 1, downstream acceptance.
REQ-014 SHALL have mantissa_o output N, recovered uncorrected mantissa.
REQ-015 SHALL have exact_o output 1, set when f(mantissa_o)==T.

Function
REQ-016 SHALL compute the forward correction f(m) bit-exactly; SF=max(N,KF); ALPHA=int(0.27055988837249*2^CF); BETA=int(0.4294429717321613*2^CF); GAMMA_1=int(ln2/0.27055988837249*2^KF); GAMMA_2=int((2*ln2/0.4294429717321613-1)*2^KF); int() rounds to nearest.
REQ-017 SHALL, for m[N-1]=0, use a={m[N-2:0],S'b0} (N-1+S bits), coefficient ALPHA, gamma GAMMA_1; for m[N-1]=1, use a=~{m,S'b0} truncated to N-1+S bits, BETA, GAMMA_2.
REQ-018 SHALL form p1=a*coef truncated to N+CF+S-2 bits; sum=(m<<(SF-N))+(gamma<<(SF-KF)) in SF+2 bits; p2=p1*sum; r=p2>>(SF+CF+S-NS) truncated to N+NS bits; f=((m[N-1]? ~r : r)>>NS) truncated to N bits.
REQ-019 SHALL compute the result by MSB-first bisection: R=0; for k=N-1..0: C=R|(1<<k); if f(C)<=T then R=C; one bit per cycle, one f evaluation per cycle.
REQ-020 SHALL use FSM states IDLE, SEARCH, DONE; reset and clear state IDLE.
REQ-021 SHALL assert ready_o only in IDLE; valid_i&&ready_o at an edge registers T, clears R, loads bit counter k=N-1, enters SEARCH.
REQ-022 SHALL in SEARCH resolve bit k each cycle and decrement k; after resolving k=0 enter DONE; valid_i is ignored outside IDLE.
REQ-023 SHALL assert valid_o only in DONE, first seen N cycles after the accept edge; mantissa_o=R, exact_o=(f(R)==T), both registered.
REQ-024 SHALL hold valid_o, mantissa_o, exact_o stable while valid_o&&!ready_i; valid_o&&ready_i returns to IDLE next cycle; throughput one result per N+2 cycles.
REQ-025 SHALL give clear_i priority over all other events: next state IDLE, T, R, k, outputs zeroed; a handshake coinciding with clear_i is discarded.
REQ-026 SHALL produce T=0 result per REQ-019 (not forced 0); f need not be monotone, REQ-019 is normative.

Reset
REQ-027 SHALL, while rst_ni=0, force state IDLE, T=R=k=0, ready_o=1, valid_o=0, mantissa_o=0, exact_o=0, independent of clk_i.
REQ-028 SHALL accept a request on the first rising edge after rst_ni deassertion; reset mid-SEARCH or mid-DONE discards the transaction.

Verification (defaults N=7, CF=KF=7, S=1, NS=0; ALPHA=35, BETA=55, GAMMA_1=328, GAMMA_2=285)
REQ-029 SHALL verify T=53 -> mantissa_o=64 (f(64)=53, f(65)=54), exact_o=1, valid_o 7 cycles after accept.
REQ-030 SHALL verify T=24 -> 32 (f(32)=24, f(33)=25), exact_o=1; T=127 -> 127, exact_o=1.
REQ-031 SHALL verify T=0 -> 1 (f(1)=0, f(2)=1), exact_o=1.
REQ-032 SHALL verify ready_i=0 for 5 cycles in DONE -> outputs stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE, ready_o=1 next cycle.
REQ-033 SHALL verify clear_i at third SEARCH cycle -> IDLE next cycle, valid_o never asserted, next T=53 -> 64.
REQ-034 SHALL verify random T over all 2^N values against a model of REQ-016..REQ-019, plus rst_ni pulse mid-SEARCH -> all outputs reset immediately.
